// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto one shared memory port,
// one transfer in flight, data priority with a starvation guard for fetch.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t      state;
  logic        owner_d, we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  lat_cnt, starve_cnt;
  logic        idle, gnt_d, gnt_f, in_acc, in_resp;
  logic [31:0] req_addr;
  // Grants are combinational so a request dropped before acceptance never wins
  assign idle     = rst_n && state == IDLE;
  assign gnt_d    = idle && dm_req && !(if_req && starve_cnt == LIM);
  assign gnt_f    = idle && if_req && !gnt_d;
  assign req_addr = gnt_d ? dm_addr : if_addr;
  assign in_acc   = state == ACCESS;
  assign in_resp  = state == RESP;
  assign if_gnt    = gnt_f;
  assign dm_gnt    = gnt_d;
  assign if_rvalid = in_resp && !owner_d;
  assign dm_rvalid = in_resp && owner_d;
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign dm_rdata  = dm_rvalid ? rdata_q : '0;
  assign if_err    = if_rvalid && err_q;
  assign dm_err    = dm_rvalid && err_q;
  assign mem_en    = in_acc;
  assign mem_we    = in_acc && we_q;
  assign mem_addr  = in_acc ? addr_q : '0;
  assign mem_wdata = in_acc ? wdata_q : '0;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else if (gnt_d || gnt_f) begin
      owner_d    <= gnt_d;
      we_q       <= gnt_d && dm_we;
      addr_q     <= req_addr;
      wdata_q    <= gnt_d ? dm_wdata : '0;
      rdata_q    <= '0;
      err_q      <= |req_addr[1:0];
      lat_cnt    <= LAT;
      state      <= |req_addr[1:0] ? RESP : ACCESS;
      starve_cnt <= gnt_f ? '0 : (if_req && starve_cnt < LIM) ? starve_cnt + 4'd1 : starve_cnt;
    end else if (in_acc) begin
      lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd1) begin
        state   <= RESP;
        rdata_q <= we_q ? '0 : mem_rdata;
      end
    end else if (in_resp) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// transaction-level model that predicts every output from grant-relative timing.
module tb_mem_arbiter;
  localparam int L   = 2;
  localparam int LIM = 4;
  logic        clk = 0, rst_n = 0;
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic        if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  int errors = 0, checks = 0, cyc = 0;
  logic        m_active = 0, m_side = 0, m_we = 0, m_mis = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_word = 0;
  int          m_gcyc = 0, m_starve = 0, m_lastg = 0;
  logic        s_if_gnt, s_dm_gnt, s_mem_en, s_mem_we, s_if_rvalid, s_dm_rvalid, s_dm_err;
  logic [31:0] s_if_rdata, s_dm_rdata;

  mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] raddr();
    logic [1:0] lo;
    lo = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return {22'b0, 8'($urandom), lo};
  endfunction

  // One clock cycle: predict, sample at negedge, compare, advance the model.
  task automatic step();
    logic e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_err, e_busy;
    logic [31:0] e_addr, e_wd, e_rd;
    int k;
    k = cyc - m_gcyc;
    {e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_err, e_busy} = '0;
    {e_addr, e_wd, e_rd} = '0;
    if (rst_n) begin
      if (m_active) begin
        e_busy = 1;
        if (!m_mis && k <= L) begin
          e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata;
        end else begin
          e_irv = !m_side; e_drv = m_side; e_err = m_mis;
          e_rd = (m_mis || m_we) ? 32'h0 : m_word;
        end
      end else begin
        e_dg = dm_req && !(if_req && m_starve == LIM);
        e_ig = if_req && !e_dg;
      end
    end
    @(negedge clk);
    s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_mem_en = mem_en; s_mem_we = mem_we;
    s_if_rvalid = if_rvalid; s_dm_rvalid = dm_rvalid; s_dm_err = dm_err;
    s_if_rdata = if_rdata; s_dm_rdata = dm_rdata;
    chk("if_gnt", if_gnt, e_ig);
    chk("dm_gnt", dm_gnt, e_dg);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_rvalid", if_rvalid, e_irv);
    chk("if_rdata", if_rdata, e_irv ? e_rd : 32'h0);
    chk("if_err", if_err, e_irv && e_err);
    chk("dm_rvalid", dm_rvalid, e_drv);
    chk("dm_rdata", dm_rdata, e_drv ? e_rd : 32'h0);
    chk("dm_err", dm_err, e_drv && e_err);
    chk("busy", busy, e_busy);
    m_lastg = 0;
    if (!rst_n) begin
      m_active = 0; m_starve = 0;
    end else if (m_active) begin
      if (!m_mis && k == L) begin
        if (m_we) model_mem[m_addr[9:2]] = m_wdata;
        else m_word = model_mem[m_addr[9:2]];
      end
      if (m_mis || k == L + 1) m_active = 0;
    end else if (e_dg || e_ig) begin
      m_active = 1; m_gcyc = cyc; m_side = e_dg;
      m_addr = e_dg ? dm_addr : if_addr;
      m_we = e_dg && dm_we;
      m_wdata = e_dg ? dm_wdata : 32'h0;
      m_mis = m_addr[1:0] != 2'b00;
      m_lastg = e_dg ? 2 : 1;
      if (e_ig) m_starve = 0;
      else if (if_req && m_starve < LIM) m_starve++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    if_req = 0; dm_req = 0;
    for (int i = 0; i < 40 && m_active; i++) step();
  endtask

  initial begin
    string seq;
    logic [31:0] old20;
    int rv;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; model_mem[i] = mem[i];
    end
    mem[16] = 32'h8C010004; model_mem[16] = 32'h8C010004;
    dm_req = 1;
    @(posedge clk); #1;
    step(); step();
    chk("reset_dm_gnt", s_dm_gnt, 0);
    chk("reset_mem_en", s_mem_en, 0);
    rst_n = 1;
    step();
    chk("first_grant_after_reset", s_dm_gnt, 1);
    drain();
    // fetch from 0x40
    if_req = 1; if_addr = 32'h40;
    step(); chk("fetch_gnt", s_if_gnt, 1); if_req = 0;
    step(); chk("fetch_en1", s_mem_en, 1);
    step(); chk("fetch_en2", s_mem_en, 1);
    step(); chk("fetch_rvalid", s_if_rvalid, 1); chk("fetch_rdata", s_if_rdata, 32'h8C010004);
    drain();
    // store then load at 0x10
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF;
    step(); chk("store_gnt", s_dm_gnt, 1); dm_req = 0;
    step(); chk("store_we1", s_mem_we, 1);
    step(); chk("store_we2", s_mem_we, 1);
    step(); chk("store_ack", s_dm_rvalid, 1); chk("store_rdata", s_dm_rdata, 0);
    dm_req = 1; dm_we = 0;
    step(); chk("load_gnt", s_dm_gnt, 1); dm_req = 0;
    step(); step();
    step(); chk("load_rvalid", s_dm_rvalid, 1); chk("load_rdata", s_dm_rdata, 32'hDEADBEEF);
    drain();
    // misaligned
    dm_req = 1; dm_we = 0; dm_addr = 32'h13;
    step(); chk("mis_gnt", s_dm_gnt, 1); dm_req = 0;
    step(); chk("mis_mem_en", s_mem_en, 0); chk("mis_rvalid", s_dm_rvalid, 1);
    chk("mis_err", s_dm_err, 1); chk("mis_rdata", s_dm_rdata, 0);
    drain();
    // starvation pattern with both requests held
    seq = "";
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    for (int i = 0; i < 200 && seq.len() < 10; i++) begin
      step();
      if (s_dm_gnt) seq = {seq, "D"};
      if (s_if_gnt) seq = {seq, "F"};
    end
    checks++;
    if (seq != "DDDDFDDDDF") begin
      errors++;
      $display("FAIL starve_seq: got %s expected DDDDFDDDDF", seq);
    end
    drain();
    // reset during first ACCESS cycle of a store to 0x20
    old20 = mem[8];
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = ~old20;
    step(); dm_req = 0;
    chk("pre_rst_mem_we", mem_we, 1);
    #2 rst_n = 0;
    #1 chk("rst_async_mem_en", mem_en, 0); chk("rst_async_busy", busy, 0);
    chk("rst_async_mem_addr", mem_addr, 0);
    step(); step();
    rst_n = 1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin step(); rv += int'(s_dm_rvalid); end
    chk("rst_no_rvalid", rv, 0);
    chk("rst_mem20", mem[8], old20);
    chk("rst_model_mem20", model_mem[8], old20);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || m_lastg == 1) begin
        if_req = ($urandom % 3 == 0); if_addr = raddr();
      end else if ($urandom % 32 == 0) if_req = 0;
      if (!dm_req || m_lastg == 2) begin
        dm_req = ($urandom % 2 == 0); dm_we = $urandom % 2 == 0;
        dm_addr = raddr(); dm_wdata = $urandom;
      end else if ($urandom % 32 == 0) dm_req = 0;
      step();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
